// File: rtl/ft_error_detector_if.sv
// Lockstep comparator bus: writeback and PC ports of both cores, the controller
// handshake, and the detector's status outputs.
interface ft_error_detector_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 8
);
    logic                  enable_i;
    logic                  a_we_i;
    logic [ADDR_WIDTH-1:0] a_addr_i;
    logic [DATA_WIDTH-1:0] a_wdata_i;
    logic                  a_pc_valid_i;
    logic [DATA_WIDTH-1:0] a_pc_i;
    logic                  b_we_i;
    logic [ADDR_WIDTH-1:0] b_addr_i;
    logic [DATA_WIDTH-1:0] b_wdata_i;
    logic                  b_pc_valid_i;
    logic [DATA_WIDTH-1:0] b_pc_i;
    logic                  resume_i;
    logic                  error_o;
    logic                  in_recovery_o;
    logic [1:0]            error_cause_o;
    logic                  error_sticky_o;
    logic [CNT_WIDTH-1:0]  error_count_o;

    modport master (
        output enable_i, a_we_i, a_addr_i, a_wdata_i, a_pc_valid_i, a_pc_i,
        output b_we_i, b_addr_i, b_wdata_i, b_pc_valid_i, b_pc_i, resume_i,
        input  error_o, in_recovery_o, error_cause_o, error_sticky_o, error_count_o
    );

    modport slave (
        input  enable_i, a_we_i, a_addr_i, a_wdata_i, a_pc_valid_i, a_pc_i,
        input  b_we_i, b_addr_i, b_wdata_i, b_pc_valid_i, b_pc_i, resume_i,
        output error_o, in_recovery_o, error_cause_o, error_sticky_o, error_count_o
    );
endinterface

// File: rtl/ft_error_detector.sv
// Dual-lockstep comparator: two-stage registered compare of core A/B writeback
// and PC, followed by an error/recovery/blanking state machine.
module ft_error_detector #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int CNT_WIDTH    = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    ft_error_detector_if.slave   bus
);
    localparam int BW = $clog2(BLANK_CYCLES + 1);

    typedef enum logic [1:0] {MONITOR, FLAG, RECOVER, BLANK} state_t;

    state_t               state_reg;
    logic [BW-1:0]        blank_reg;
    logic                 error_reg;
    logic                 in_recovery_reg;
    logic [1:0]           cause_reg;
    logic                 sticky_reg;
    logic [CNT_WIDTH-1:0] count_reg;

    logic                  core_we       [2];
    logic [ADDR_WIDTH-1:0] core_addr     [2];
    logic [DATA_WIDTH-1:0] core_wdata    [2];
    logic                  core_pc_valid [2];
    logic [DATA_WIDTH-1:0] core_pc       [2];

    assign core_we[0]       = bus.a_we_i;
    assign core_addr[0]     = bus.a_addr_i;
    assign core_wdata[0]    = bus.a_wdata_i;
    assign core_pc_valid[0] = bus.a_pc_valid_i;
    assign core_pc[0]       = bus.a_pc_i;
    assign core_we[1]       = bus.b_we_i;
    assign core_addr[1]     = bus.b_addr_i;
    assign core_wdata[1]    = bus.b_wdata_i;
    assign core_pc_valid[1] = bus.b_pc_valid_i;
    assign core_pc[1]       = bus.b_pc_i;

    // Stage 1 data capture, one identical register set per core
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_s1
            logic                  we_reg;
            logic [ADDR_WIDTH-1:0] addr_reg;
            logic [DATA_WIDTH-1:0] wdata_reg;
            logic                  pc_valid_reg;
            logic [DATA_WIDTH-1:0] pc_reg;

            always_ff @(posedge clk_i) begin
                we_reg       <= core_we[gi];
                addr_reg     <= core_addr[gi];
                wdata_reg    <= core_wdata[gi];
                pc_valid_reg <= core_pc_valid[gi];
                pc_reg       <= core_pc[gi];
            end
        end
    endgenerate

    logic s1_valid_reg;
    logic s2_valid_reg;
    logic s2_wb_mis_reg;
    logic s2_pc_mis_reg;
    logic wb_mis;
    logic pc_mis;
    logic flush;
    logic mismatch_q;
    logic take_error;

    // Address and data only matter when both cores actually write
    assign wb_mis = (g_s1[0].we_reg != g_s1[1].we_reg) |
                    (g_s1[0].we_reg & g_s1[1].we_reg &
                     ((g_s1[0].addr_reg != g_s1[1].addr_reg) |
                      (g_s1[0].wdata_reg != g_s1[1].wdata_reg)));
    assign pc_mis = (g_s1[0].pc_valid_reg != g_s1[1].pc_valid_reg) |
                    (g_s1[0].pc_valid_reg & g_s1[1].pc_valid_reg &
                     (g_s1[0].pc_reg != g_s1[1].pc_reg));

    assign flush      = !bus.enable_i || (state_reg == FLAG) || (state_reg == BLANK);
    assign mismatch_q = s2_valid_reg & (s2_wb_mis_reg | s2_pc_mis_reg);
    assign take_error = bus.enable_i && mismatch_q &&
                        ((state_reg == MONITOR) || (state_reg == RECOVER));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_reg  <= 1'b0;
            s2_valid_reg  <= 1'b0;
            s2_wb_mis_reg <= 1'b0;
            s2_pc_mis_reg <= 1'b0;
        end else begin
            s1_valid_reg  <= bus.enable_i & !flush;
            s2_valid_reg  <= s1_valid_reg & !flush;
            s2_wb_mis_reg <= wb_mis;
            s2_pc_mis_reg <= pc_mis;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= MONITOR;
            blank_reg       <= '0;
            error_reg       <= 1'b0;
            in_recovery_reg <= 1'b0;
            cause_reg       <= 2'b00;
            sticky_reg      <= 1'b0;
            count_reg       <= '0;
        end else if (!bus.enable_i) begin
            state_reg       <= MONITOR;
            blank_reg       <= '0;
            error_reg       <= 1'b0;
            in_recovery_reg <= 1'b0;
        end else if (take_error) begin
            state_reg       <= FLAG;
            error_reg       <= 1'b1;
            in_recovery_reg <= 1'b1;
            cause_reg       <= {s2_pc_mis_reg, s2_wb_mis_reg};
            sticky_reg      <= 1'b1;
            if (count_reg != {CNT_WIDTH{1'b1}})
                count_reg <= count_reg + CNT_WIDTH'(1);
        end else begin
            error_reg <= 1'b0;
            case (state_reg)
                MONITOR: begin
                    in_recovery_reg <= 1'b0;
                end
                FLAG: begin
                    state_reg       <= RECOVER;
                    in_recovery_reg <= 1'b1;
                end
                RECOVER: begin
                    in_recovery_reg <= 1'b1;
                    if (bus.resume_i) begin
                        state_reg <= BLANK;
                        blank_reg <= BW'(BLANK_CYCLES);
                    end
                end
                BLANK: begin
                    blank_reg <= blank_reg - BW'(1);
                    if (blank_reg == BW'(1)) begin
                        state_reg       <= MONITOR;
                        in_recovery_reg <= 1'b0;
                    end else begin
                        in_recovery_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg       <= MONITOR;
                    in_recovery_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.error_o        = error_reg;
    assign bus.in_recovery_o  = in_recovery_reg;
    assign bus.error_cause_o  = cause_reg;
    assign bus.error_sticky_o = sticky_reg;
    assign bus.error_count_o  = count_reg;
endmodule

// File: tb/tb_ft_error_detector.sv
// Bench for ft_error_detector: directed lockstep scenarios plus a random phase,
// all checked every cycle against a cycle-level behavioural model.
module tb_ft_error_detector;
    localparam int DW      = 32;
    localparam int AW      = 5;
    localparam int CW      = 2;
    localparam int BLANK   = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_PULSE = 1;
    localparam int M_WAIT  = 2;
    localparam int M_MASK  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ft_error_detector_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

    ft_error_detector #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW), .BLANK_CYCLES(BLANK)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;
    int err_n = 0;
    int last_err_cyc = -1;

    typedef struct packed { bit v; bit wb; bit pc; } ent_t;
    ent_t q[$];
    int   mode;
    int   left;
    bit   e_err, e_rec, e_sticky;
    bit [1:0] e_cause;
    int   e_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    // A core's writeback is an event (addr,data) or nothing; the cores diverge when events differ
    function automatic bit wb_diff();
        logic [AW+DW:0] ea, eb;
        ea = bus.a_we_i ? {1'b1, bus.a_addr_i, bus.a_wdata_i} : '0;
        eb = bus.b_we_i ? {1'b1, bus.b_addr_i, bus.b_wdata_i} : '0;
        return ea != eb;
    endfunction

    function automatic bit pc_diff();
        logic [DW:0] ea, eb;
        ea = bus.a_pc_valid_i ? {1'b1, bus.a_pc_i} : '0;
        eb = bus.b_pc_valid_i ? {1'b1, bus.b_pc_i} : '0;
        return ea != eb;
    endfunction

    task automatic model_edge();
        ent_t old, nw;
        bit   mq, flush, en;
        en = bus.enable_i;
        if (rst) begin
            q.delete();
            q.push_back('0);
            q.push_back('0);
            mode = M_IDLE; left = 0;
            e_err = 0; e_cause = 0; e_sticky = 0; e_cnt = 0;
        end else begin
            old   = q[0];
            mq    = old.v && (old.wb || old.pc);
            flush = !en || mode == M_PULSE || mode == M_MASK;
            nw.v  = en; nw.wb = wb_diff(); nw.pc = pc_diff();
            void'(q.pop_front());
            q.push_back(nw);
            if (flush) foreach (q[i]) q[i].v = 1'b0;
            e_err = 0;
            if (!en) mode = M_IDLE;
            else if ((mode == M_IDLE || mode == M_WAIT) && mq) begin
                mode = M_PULSE; e_err = 1; e_cause = {old.pc, old.wb}; e_sticky = 1;
                if (e_cnt < CNT_MAX) e_cnt++;
            end else if (mode == M_PULSE) mode = M_WAIT;
            else if (mode == M_WAIT && bus.resume_i) begin
                mode = M_MASK; left = BLANK;
            end else if (mode == M_MASK) begin
                left--;
                if (left == 0) mode = M_IDLE;
            end
        end
        e_rec = (mode != M_IDLE);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("error_o", bus.error_o, e_err);
        chk("in_recovery_o", bus.in_recovery_o, e_rec);
        chk("error_cause_o", bus.error_cause_o, e_cause);
        chk("error_sticky_o", bus.error_sticky_o, e_sticky);
        chk("error_count_o", bus.error_count_o, e_cnt);
        if (bus.error_o) begin
            err_n++;
            last_err_cyc = cyc + 1;
        end
        cyc++;
    endtask

    task automatic drive_same();
        bus.a_we_i       = 1'($urandom_range(0, 1));
        bus.a_addr_i     = AW'($urandom);
        bus.a_wdata_i    = $urandom;
        bus.a_pc_valid_i = 1'($urandom_range(0, 1));
        bus.a_pc_i       = $urandom;
        bus.b_we_i       = bus.a_we_i;
        bus.b_addr_i     = bus.a_addr_i;
        bus.b_wdata_i    = bus.a_wdata_i;
        bus.b_pc_valid_i = bus.a_pc_valid_i;
        bus.b_pc_i       = bus.a_pc_i;
    endtask

    task automatic drive_diverge(input int kind);
        drive_same();
        case (kind)
            0: begin bus.a_we_i = 1; bus.b_we_i = 1; bus.b_wdata_i = bus.a_wdata_i ^ 32'h1; end
            1: begin bus.b_we_i = !bus.a_we_i; end
            2: begin bus.a_pc_valid_i = 1; bus.b_pc_valid_i = 1; bus.b_pc_i = bus.a_pc_i + 4; end
            3: begin bus.b_pc_valid_i = !bus.a_pc_valid_i; end
            default: begin bus.a_we_i = 1; bus.b_we_i = 1; bus.b_addr_i = bus.a_addr_i ^ 5'h1; end
        endcase
    endtask

    task automatic do_reset();
        rst = 1; bus.enable_i = 1; bus.resume_i = 0;
        drive_same();
        step();
        chk("rst_error_o", bus.error_o, 1'b0);
        chk("rst_count", bus.error_count_o, '0);
        rst = 0;
        cyc = 0; err_n = 0; last_err_cyc = -1;
    endtask

    int s, r, rec_len;
    logic [CW-1:0] cnt_hold;

    initial begin
        bus.enable_i = 1; bus.resume_i = 0;
        drive_same();

        // Identical streams never flag
        do_reset();
        for (int i = 0; i < 1000; i++) begin drive_same(); step(); end
        chk("ident_err_n", err_n, 0);
        chk("ident_count", bus.error_count_o, '0);
        chk("ident_sticky", bus.error_sticky_o, 1'b0);
        $display("identical stream: cycles=%0d errors=%0d", cyc, err_n);

        // Writeback data divergence at cycle 10
        do_reset();
        for (int i = 0; i < 10; i++) begin drive_same(); step(); end
        drive_same();
        bus.a_we_i = 1; bus.b_we_i = 1;
        bus.a_wdata_i = 32'hDEADBEEF; bus.b_wdata_i = 32'hDEADBEEE;
        step();
        for (int i = 0; i < 6; i++) begin drive_same(); step(); end
        chk("wb_err_cyc", last_err_cyc, 13);
        chk("wb_err_n", err_n, 1);
        chk("wb_cause", bus.error_cause_o, 2'b01);
        chk("wb_count", bus.error_count_o, 2'd1);
        chk("wb_in_rec", bus.in_recovery_o, 1'b1);
        $display("wb divergence: err_cyc=%0d cause=%b", last_err_cyc, bus.error_cause_o);

        // PC divergence at 10; addr differing with both we low at 5 is harmless
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive_same();
            if (i == 5) begin bus.a_we_i = 0; bus.b_we_i = 0; bus.b_addr_i = bus.a_addr_i ^ 5'h3; end
            step();
        end
        drive_same();
        bus.a_pc_valid_i = 1; bus.b_pc_valid_i = 1;
        bus.a_pc_i = 32'h100; bus.b_pc_i = 32'h104;
        bus.a_we_i = 0; bus.b_we_i = 0; bus.b_addr_i = bus.a_addr_i ^ 5'h1;
        step();
        for (int i = 0; i < 6; i++) begin drive_same(); step(); end
        chk("pc_err_cyc", last_err_cyc, 13);
        chk("pc_err_n", err_n, 1);
        chk("pc_cause", bus.error_cause_o, 2'b10);
        $display("pc divergence: err_cyc=%0d cause=%b", last_err_cyc, bus.error_cause_o);

        // Mismatch and resume in the same RECOVER cycle: mismatch wins
        s = cyc;
        drive_diverge(2); step();
        drive_same(); step();
        drive_same(); bus.resume_i = 1; step();
        bus.resume_i = 0;
        for (int i = 0; i < 3; i++) begin drive_same(); step(); end
        chk("rec_err_cyc", last_err_cyc, s + 3);
        chk("rec_err_n", err_n, 2);
        chk("rec_count", bus.error_count_o, 2'd2);
        chk("rec_still_in_rec", bus.in_recovery_o, 1'b1);

        // Resume, then blank window swallows mismatches
        drive_same(); bus.resume_i = 1; step();
        bus.resume_i = 0;
        rec_len = bus.in_recovery_o ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            drive_diverge(i);
            step();
            if (bus.in_recovery_o) rec_len++;
        end
        for (int i = 0; i < 6; i++) begin drive_same(); step(); end
        chk("blank_len", rec_len, BLANK);
        chk("blank_err_n", err_n, 2);
        chk("blank_in_rec", bus.in_recovery_o, 1'b0);
        $display("recovery: errors=%0d blank_len=%0d", err_n, rec_len);

        // Saturation, then reset mid-RECOVER
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive_diverge(k); step();
            for (int i = 0; i < 4; i++) begin drive_same(); step(); end
        end
        chk("sat_err_n", err_n, 5);
        chk("sat_count", bus.error_count_o, 2'd3);
        chk("sat_sticky", bus.error_sticky_o, 1'b1);
        chk("sat_in_rec", bus.in_recovery_o, 1'b1);
        rst = 1; drive_same(); step(); rst = 0;
        chk("midrst_in_rec", bus.in_recovery_o, 1'b0);
        chk("midrst_count", bus.error_count_o, '0);
        chk("midrst_sticky", bus.error_sticky_o, 1'b0);
        chk("midrst_cause", bus.error_cause_o, 2'b00);
        $display("saturation: errors=%0d count after reset=%0d", err_n, bus.error_count_o);

        // Disable for one cycle while a mismatch sits in S2
        do_reset();
        for (int i = 0; i < 5; i++) begin drive_same(); step(); end
        drive_diverge(0); step();
        drive_same(); step();
        drive_same(); bus.enable_i = 0; step();
        chk("dis_err_n", err_n, 0);
        chk("dis_count", bus.error_count_o, '0);
        bus.enable_i = 1;
        r = cyc;
        drive_diverge(3); step();
        for (int i = 0; i < 5; i++) begin drive_same(); step(); end
        chk("reen_err_cyc", last_err_cyc, r + 3);
        chk("reen_err_n", err_n, 1);
        $display("enable gap: re-enable cyc=%0d err_cyc=%0d", r, last_err_cyc);

        // Random mix of divergence, resume, enable and reset
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) drive_diverge(int'($urandom_range(0, 4)));
            else drive_same();
            bus.resume_i = ($urandom_range(0, 7) == 0);
            bus.enable_i = ($urandom_range(0, 29) != 0);
            rst = ($urandom_range(0, 299) == 0);
            cnt_hold = bus.error_count_o;
            step();
            if (!rst && bus.error_count_o < cnt_hold)
                chk("cnt_monotonic", bus.error_count_o, cnt_hold);
        end
        rst = 0; bus.resume_i = 0; bus.enable_i = 1;
        $display("random phase: cycles=%0d errors=%0d", cyc, err_n);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
